// File: rtl/andor_pkg.sv
// Shared types and defaults for the AND/OR response checker.
// State encoding and default parameter values.
package andor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 2;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_NUM_VEC = 4;

endpackage

// File: rtl/andor_exp_pipe.sv
// LATENCY-deep valid+data shift register holding expected results.
// i_clr empties the valid chain; data words are don't-care when invalid.
module andor_exp_pipe #(
  parameter int DW      = 8,
  parameter int LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data,
  output logic          o_busy
);

  logic [LATENCY-1:0] r_vld;
  logic [DW-1:0]      r_dat [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_clr) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int i = 1; i < LATENCY; i++)
        r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++)
        r_dat[i] <= '0;
    end else begin
      r_dat[0] <= i_data;
      for (int i = 1; i < LATENCY; i++)
        r_dat[i] <= r_dat[i-1];
    end
  end

  assign o_vld  = r_vld[LATENCY-1];
  assign o_data = r_dat[LATENCY-1];
  assign o_busy = |r_vld;

endmodule

// File: rtl/andor_resp_checker.sv
// Response checker for the AND/OR unit: delays expected A&B / A|B by
// LATENCY cycles, compares with DUT results, counts and captures failures.
module andor_resp_checker
  import andor_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LATENCY     = DEF_LATENCY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int NUM_VECTORS = DEF_NUM_VEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim_a,
  input  logic [WIDTH-1:0] stim_b,
  input  logic [WIDTH-1:0] dut_and,
  input  logic [WIDTH-1:0] dut_or,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  localparam int ISS_W = $clog2(NUM_VECTORS + 1);
  localparam int DW    = 2 * WIDTH + CNT_W;
  localparam logic [ISS_W-1:0] NV = ISS_W'(NUM_VECTORS);

  state_t           r_state;
  state_t           w_next;
  logic [ISS_W-1:0] r_issued;
  logic [CNT_W-1:0] r_vec;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_ffi;
  logic             r_ffv;

  logic             w_go;
  logic             w_issue;
  logic [DW-1:0]    w_push;
  logic             w_tail_vld;
  logic [DW-1:0]    w_tail;
  logic             w_pipe_busy;
  logic [WIDTH-1:0] w_exp_and;
  logic [WIDTH-1:0] w_exp_or;
  logic [CNT_W-1:0] w_idx;
  logic             w_miss;

  assign w_go    = start && (r_state != ST_RUN);
  assign w_issue = (r_state == ST_RUN) && stim_valid
                   && (r_issued < NV);
  assign w_push  = {stim_a & stim_b, stim_a | stim_b,
                    CNT_W'(r_issued)};

  andor_exp_pipe #(
    .DW      (DW),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_go),
    .i_vld  (w_issue),
    .i_data (w_push),
    .o_vld  (w_tail_vld),
    .o_data (w_tail),
    .o_busy (w_pipe_busy)
  );

  assign w_exp_and = w_tail[DW-1 -: WIDTH];
  assign w_exp_or  = w_tail[CNT_W +: WIDTH];
  assign w_idx     = w_tail[CNT_W-1:0];
  // X on a DUT result bit must register as a mismatch
  assign w_miss    = (w_exp_and !== dut_and)
                     || (w_exp_or !== dut_or);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (r_issued == NV && !w_pipe_busy)
                 w_next = ST_DONE;
      ST_DONE: if (start) w_next = ST_RUN;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued <= '0;
      r_vec    <= '0;
      r_err    <= '0;
      r_ffi    <= '0;
      r_ffv    <= 1'b0;
    end else if (w_go) begin
      r_issued <= '0;
      r_vec    <= '0;
      r_err    <= '0;
      r_ffi    <= '0;
      r_ffv    <= 1'b0;
    end else begin
      if (w_issue)
        r_issued <= r_issued + ISS_W'(1);
      if (w_tail_vld) begin
        r_vec <= r_vec + CNT_W'(1);
        if (w_miss) begin
          if (r_err != '1)
            r_err <= r_err + CNT_W'(1);
          if (!r_ffv) begin
            r_ffi <= w_idx;
            r_ffv <= 1'b1;
          end
        end
      end
    end
  end

  assign busy           = (r_state == ST_RUN);
  assign done           = (r_state == ST_DONE);
  assign pass           = done && (r_err == '0);
  assign vec_cnt        = r_vec;
  assign err_cnt        = r_err;
  assign first_fail_idx = r_ffi;
  assign first_fail_vld = r_ffv;

endmodule

// File: tb/tb_andor_resp_checker.sv
// Directed bench for andor_resp_checker: three instances cover
// LATENCY=1, LATENCY=3 and a narrow-counter short run.
module tb_andor_resp_checker;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [1:0] va [4] = '{2'b00, 2'b10, 2'b10, 2'b11};
  logic [1:0] vb [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
  logic [1:0] ea [4] = '{2'b00, 2'b10, 2'b00, 2'b01};
  logic [1:0] eo [4] = '{2'b10, 2'b10, 2'b11, 2'b11};

  logic       st0, sv0, busy0, done0, pass0, fv0;
  logic [1:0] a0, b0, da0, do0;
  logic [7:0] vc0, ec0, fi0;

  logic       st1, sv1, busy1, done1, pass1, fv1;
  logic [1:0] a1, b1, da1, do1;
  logic [7:0] vc1, ec1, fi1;

  logic       st2, sv2, busy2, done2, pass2, fv2;
  logic [1:0] a2, b2, da2, do2;
  logic [1:0] vc2, ec2, fi2;

  andor_resp_checker #(
    .WIDTH(2), .LATENCY(1), .CNT_W(8), .NUM_VECTORS(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .stim_valid(sv0),
    .stim_a(a0), .stim_b(b0), .dut_and(da0), .dut_or(do0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_cnt(vc0),
    .err_cnt(ec0), .first_fail_idx(fi0), .first_fail_vld(fv0)
  );

  andor_resp_checker #(
    .WIDTH(2), .LATENCY(3), .CNT_W(8), .NUM_VECTORS(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .stim_valid(sv1),
    .stim_a(a1), .stim_b(b1), .dut_and(da1), .dut_or(do1),
    .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vc1),
    .err_cnt(ec1), .first_fail_idx(fi1), .first_fail_vld(fv1)
  );

  andor_resp_checker #(
    .WIDTH(2), .LATENCY(1), .CNT_W(2), .NUM_VECTORS(3)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .stim_valid(sv2),
    .stim_a(a2), .stim_b(b2), .dut_and(da2), .dut_or(do2),
    .busy(busy2), .done(done2), .pass(pass2), .vec_cnt(vc2),
    .err_cnt(ec2), .first_fail_idx(fi2), .first_fail_vld(fv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0 clean, 1 AandB=01 on vector 2, 2 AorB stuck at 00
  task automatic run0(input int mode);
    st0 = 1'b1;
    step();
    st0 = 1'b0;
    for (int t = 0; t < 5; t++) begin
      sv0 = (t < 4);
      if (t < 4) begin
        a0 = va[t];
        b0 = vb[t];
      end
      if (t > 0) begin
        da0 = ea[t-1];
        do0 = eo[t-1];
        if (mode == 1 && t == 3) da0 = 2'b01;
        if (mode == 2) do0 = 2'b00;
      end
      step();
      if (t == 1 && mode == 0) begin
        chk("run_busy", 32'(busy0), 32'd1);
        chk("run_nodone", 32'(done0), 32'd0);
      end
    end
    sv0 = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    {st0, sv0, a0, b0, da0, do0} = '0;
    {st1, sv1, a1, b1, da1, do1} = '0;
    {st2, sv2, a2, b2, da2, do2} = '0;
    #12;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_vec", 32'(vc0), 32'd0);
    rst_n = 1'b1;
    step();

    run0(0);
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_pass", 32'(pass0), 32'd1);
    chk("t1_vec", 32'(vc0), 32'd4);
    chk("t1_err", 32'(ec0), 32'd0);
    chk("t1_ffv", 32'(fv0), 32'd0);
    chk("t1_busy", 32'(busy0), 32'd0);

    run0(1);
    chk("t2_err", 32'(ec0), 32'd1);
    chk("t2_ffi", 32'(fi0), 32'd2);
    chk("t2_ffv", 32'(fv0), 32'd1);
    chk("t2_pass", 32'(pass0), 32'd0);
    chk("t2_done", 32'(done0), 32'd1);

    run0(2);
    chk("t3_err", 32'(ec0), 32'd4);
    chk("t3_ffi", 32'(fi0), 32'd0);
    chk("t3_vec", 32'(vc0), 32'd4);

    // abort mid-run with a mismatch already captured
    st0 = 1'b1;
    step();
    st0 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      sv0 = 1'b1;
      a0 = va[t];
      b0 = vb[t];
      if (t > 0) begin
        da0 = ~ea[t-1];
        do0 = eo[t-1];
      end
      step();
    end
    chk("t5_pre_vec", 32'(vc0), 32'd2);
    chk("t5_pre_err", 32'(ec0), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy0), 32'd0);
    chk("t5_rst_vec", 32'(vc0), 32'd0);
    chk("t5_rst_err", 32'(ec0), 32'd0);
    chk("t5_rst_ffv", 32'(fv0), 32'd0);
    chk("t5_rst_done", 32'(done0), 32'd0);
    sv0 = 1'b0;
    rst_n = 1'b1;
    step();
    run0(0);
    chk("t5_pass", 32'(pass0), 32'd1);
    chk("t5_vec", 32'(vc0), 32'd4);

    // LATENCY=3: stim ignored in IDLE, then back-to-back run
    sv1 = 1'b1;
    a1 = 2'b11;
    b1 = 2'b11;
    step();
    step();
    sv1 = 1'b0;
    chk("t4_idle_vec", 32'(vc1), 32'd0);
    chk("t4_idle_busy", 32'(busy1), 32'd0);
    st1 = 1'b1;
    step();
    st1 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      sv1 = (t < 4);
      if (t < 4) begin
        a1 = va[t];
        b1 = vb[t];
      end
      if (t >= 3 && t < 7) begin
        da1 = ea[t-3];
        do1 = eo[t-3];
      end
      step();
      if (t == 2) chk("t4_vec_e2", 32'(vc1), 32'd0);
      if (t == 3) chk("t4_vec_e3", 32'(vc1), 32'd1);
      if (t == 6) begin
        chk("t4_vec_e6", 32'(vc1), 32'd4);
        chk("t4_done_e6", 32'(done1), 32'd0);
      end
      if (t == 7) begin
        chk("t4_done_e7", 32'(done1), 32'd1);
        chk("t4_pass", 32'(pass1), 32'd1);
      end
    end
    sv1 = 1'b1;
    step();
    step();
    sv1 = 1'b0;
    chk("t4_post_vec", 32'(vc1), 32'd4);
    chk("t4_post_done", 32'(done1), 32'd1);

    // CNT_W=2, 3 vectors, all wrong, start mid-run ignored
    st2 = 1'b1;
    step();
    st2 = 1'b0;
    for (int t = 0; t < 5; t++) begin
      sv2 = (t < 3);
      st2 = (t == 2);
      if (t < 3) begin
        a2 = va[t];
        b2 = vb[t];
      end
      if (t >= 1 && t <= 3) begin
        da2 = ~ea[t-1];
        do2 = eo[t-1];
      end
      step();
      if (t == 2) chk("t6_err_e2", 32'(ec2), 32'd2);
      if (t == 3) chk("t6_err_e3", 32'(ec2), 32'd3);
    end
    st2 = 1'b0;
    chk("t6_done", 32'(done2), 32'd1);
    chk("t6_err", 32'(ec2), 32'd3);
    chk("t6_vec", 32'(vc2), 32'd3);
    chk("t6_pass", 32'(pass2), 32'd0);
    chk("t6_ffi", 32'(fi2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
